// File: rtl/rst_seq_pkg.sv
// Shared definitions for the board-level reset sequencer.
//   - State encodings reported on state_dbg (HOLD/STRETCH/RELEASE/RUN).
//   - clog2_min1(): ceiling log2 clamped to at least 1, used to size
//     counters so that degenerate parameter choices still give a legal width.
package rst_seq_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << width) < 64'(value)) begin
                width = width + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by an optional debounce filter.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (clears the synchroniser,
//            loads the filtered output with RESET_VAL)
//   din    : raw asynchronous input
//   flip   : already-synchronous polarity modifier, XORed after the sync
//   dout   : filtered (or, with BYPASS, merely synchronised) level
// With BYPASS=1 the debounce counter is not built and dout is the
// synchronised level (XOR INVERT XOR flip).
// Without BYPASS, dout only follows the synchronised level after it has
// disagreed with dout for 2^DEBOUNCE_BITS consecutive cycles.
module debounce_sync #(
    parameter int DEBOUNCE_BITS = 16,
    parameter bit BYPASS        = 1'b0,
    parameter bit INVERT        = 1'b0,
    parameter bit RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic flip,
    output logic dout
);

    logic [1:0] sync;
    logic       raw;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], din};
        end
    end

    assign raw = sync[1] ^ INVERT ^ flip;

    if (BYPASS) begin : g_bypass
        assign dout = raw;
    end else begin : g_debounce
        logic [DEBOUNCE_BITS-1:0] cnt;
        logic                     db;

        // The counter only runs while the input disagrees with the held
        // level; any agreement restarts it, so short glitches vanish.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                db  <= RESET_VAL;
            end else if (raw == db) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                db  <= raw;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign dout = db;
    end

endmodule

// File: rtl/reset_sequencer.sv
// Board-level multi-domain reset sequencer.
//   clk         : system clock
//   reset_in    : asynchronous active-low master reset
//   pll_locked  : PLL lock, asynchronous (synchronised, not debounced)
//   key_n       : raw push-button, low = pressed (synchronised + debounced)
//   sw_invert   : raw switch that inverts the button sense
//   reset_out_n : per-domain active-low resets, bit 0 released first
//   ready       : high once every domain is released (RUN)
//   state_dbg   : current state encoding
//   reset_count : saturating count of reset entries from a non-HOLD state
// Sequence: HOLD until button released and PLL locked, STRETCH for
// STRETCH_CYCLES cycles, RELEASE domains STAGE_GAP cycles apart, RUN.
// Any abort (button active or lock lost) returns to HOLD in one edge.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 2,
    parameter int DEBOUNCE_BITS  = 16,
    parameter int STRETCH_CYCLES = 1024,
    parameter int STAGE_GAP      = 16
) (
    input  logic                   clk,
    input  logic                   reset_in,
    input  logic                   pll_locked,
    input  logic                   key_n,
    input  logic                   sw_invert,
    output logic [NUM_DOMAINS-1:0] reset_out_n,
    output logic                   ready,
    output logic [1:0]             state_dbg,
    output logic [7:0]             reset_count
);

    localparam int REL_LAST = (NUM_DOMAINS - 1) * STAGE_GAP;
    localparam int REL_W    = clog2_min1(REL_LAST + 1);
    localparam int STR_W    = clog2_min1(STRETCH_CYCLES);

    localparam logic [REL_W-1:0] REL_LAST_V = REL_W'(REL_LAST);
    localparam logic [STR_W-1:0] STR_LOAD   = STR_W'(STRETCH_CYCLES - 1);

    logic                   sw_s;
    logic                   lock_s;
    logic                   btn_db;
    logic                   abort;
    logic [1:0]             state;
    logic [STR_W-1:0]       str_cnt;
    logic [REL_W-1:0]       rel_cnt;
    logic [NUM_DOMAINS-1:0] stage_due;

    debounce_sync #(
        .DEBOUNCE_BITS(1), .BYPASS(1'b1), .INVERT(1'b0), .RESET_VAL(1'b0)
    ) u_sw_sync (
        .clk(clk), .rst_n(reset_in), .din(sw_invert), .flip(1'b0), .dout(sw_s)
    );

    debounce_sync #(
        .DEBOUNCE_BITS(1), .BYPASS(1'b1), .INVERT(1'b0), .RESET_VAL(1'b0)
    ) u_lock_sync (
        .clk(clk), .rst_n(reset_in), .din(pll_locked), .flip(1'b0), .dout(lock_s)
    );

    // Button is active when ~key_s ^ sw_s; it comes out of reset "pressed"
    // so the board stays held until the filter has seen a clean release.
    debounce_sync #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS), .BYPASS(1'b0), .INVERT(1'b1), .RESET_VAL(1'b1)
    ) u_key_db (
        .clk(clk), .rst_n(reset_in), .din(key_n), .flip(sw_s), .dout(btn_db)
    );

    assign abort = btn_db | ~lock_s;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stage_due = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            stage_due[i] = (int'(rel_cnt) >= i * STAGE_GAP);
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state       <= ST_HOLD;
            str_cnt     <= '0;
            rel_cnt     <= '0;
            reset_out_n <= '0;
            ready       <= 1'b0;
            reset_count <= '0;
        end else if (abort) begin
            // All domains drop together; only a real exit from the
            // sequence is counted, not a continued hold.
            state       <= ST_HOLD;
            str_cnt     <= '0;
            rel_cnt     <= '0;
            reset_out_n <= '0;
            ready       <= 1'b0;
            if (state != ST_HOLD && reset_count != 8'hFF) begin
                reset_count <= reset_count + 8'd1;
            end
        end else begin
            case (state)
                ST_HOLD: begin
                    state   <= ST_STRETCH;
                    str_cnt <= STR_LOAD;
                end
                ST_STRETCH: begin
                    if (str_cnt == '0) begin
                        state   <= ST_RELEASE;
                        rel_cnt <= '0;
                    end else begin
                        str_cnt <= str_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt == REL_LAST_V) begin
                        state       <= ST_RUN;
                        ready       <= 1'b1;
                        reset_out_n <= '1;
                    end else begin
                        // OR keeps released domains high; none ever drops alone.
                        reset_out_n <= reset_out_n | stage_due;
                        rel_cnt     <= rel_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised board-level reset controller that generalises the toplevel reset scheme (button XOR switch, gated by PLL lock) into a multi-domain sequencer. It synchronises and debounces the reset button, waits for PLL lock, stretches reset, then releases NUM_DOMAINS reset outputs in staged order. It sits between the PLL/board inputs and SDRAMTest plus any other clock-domain consumers on the toplevel.

Parameters:
NUM_DOMAINS, 2, number of staged reset outputs (1..8)
DEBOUNCE_BITS, 16, debounce counter width; button must be stable for 2^DEBOUNCE_BITS cycles
STRETCH_CYCLES, 1024, minimum cycles reset is held after lock and button are clean (>=1)
STAGE_GAP, 16, cycles between successive domain releases (>=1)

Ports:
clk  in  1  system clock
reset_in  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock, asynchronous to clk
key_n  in  1  raw push-button, low = pressed
sw_invert  in  1  raw switch; inverts button sense (button_active = ~key_n ^ sw_invert)
reset_out_n  out  NUM_DOMAINS  per-domain active-low reset, bit 0 released first
ready  out  1  high when all domains released (state RUN)
state_dbg  out  2  current state encoding
reset_count  out  8  saturating count of reset entries

Behaviour:
- reset_in low (async): state=HOLD, reset_out_n=0, ready=0, reset_count=0, all counters and synchronisers cleared, debounced button = active.
- pll_locked, key_n and sw_invert each pass through a 2-flop synchroniser; btn_raw = ~key_s ^ sw_s.
- Debounce: cnt clears when btn_raw == btn_db; increments while they differ; when cnt == 2^DEBOUNCE_BITS-1 and still differing, btn_db <= btn_raw, cnt <= 0. A glitch shorter than 2^DEBOUNCE_BITS cycles never changes btn_db. pll_locked is not debounced.
- abort = btn_db | ~lock_s. Evaluated every cycle in every state; overrides all other transitions.
- States (state_dbg): HOLD=0, STRETCH=1, RELEASE=2, RUN=3.
- HOLD: all outputs low. Exit to STRETCH when abort=0; stretch counter loads STRETCH_CYCLES-1.
- STRETCH: counter decrements; at 0 go to RELEASE with rel_cnt=0. STRETCH lasts exactly STRETCH_CYCLES cycles.
- RELEASE: rel_cnt increments each cycle; reset_out_n[i] registered high when rel_cnt >= i*STAGE_GAP (bit 0 high on first RELEASE edge). When rel_cnt == (NUM_DOMAINS-1)*STAGE_GAP go to RUN.
- RUN: all reset_out_n high, ready=1 (registered, same edge as entry).
- abort=1 in STRETCH/RELEASE/RUN: next edge state=HOLD, all reset_out_n=0 simultaneously, ready=0, reset_count += 1 saturating at 255. Abort while already in HOLD does not count.
- Lock loss latency: pll_locked falling to reset_out_n low = 3 clk edges (2 sync + 1 register).
- Once released, an output stays high until the next abort; no output ever deasserts individually.
- NUM_DOMAINS=1: RELEASE lasts one cycle then RUN.
- rel_cnt width = clog2((NUM_DOMAINS-1)*STAGE_GAP+1), min 1; stretch counter width = clog2(STRETCH_CYCLES), min 1.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package rst_seq_pkg: state encoding constants (HOLD/STRETCH/RELEASE/RUN), clog2 function.
- One sub-module: debounce_sync (2-flop synchroniser + debounce counter, parameter DEBOUNCE_BITS, async active-low reset, reset value parameterised). The pll_locked and sw_invert synchronisers reuse its sync stage with DEBOUNCE_BITS bypassed via a BYPASS parameter.

Test Plan:
- Params NUM_DOMAINS=3, DEBOUNCE_BITS=4, STRETCH_CYCLES=8, STAGE_GAP=4; key_n=1, sw_invert=0, pll_locked=1 from reset_in release -> btn_db clears after 2+16 cycles; STRETCH 8 cycles; reset_out_n goes 001, 011, 111 at 4-cycle spacing; ready=1 with 111; reset_count=0.
- In RUN, drop pll_locked for 1 cycle -> exactly 3 edges later reset_out_n=000, ready=0, state_dbg=0, reset_count=1; full sequence repeats after lock returns.
- In RUN, pulse key_n low for 10 cycles -> no change (debounced out); hold low for 20 cycles -> reset_out_n=000 after 2+16+1 edges, reset_count=1.
- sw_invert=1 with key_n=1 -> button treated as pressed: stays in HOLD; key_n=0 held -> sequence proceeds to RUN.
- Abort in RELEASE after bit 0 released (reset_out_n=001) -> next edge 000, state HOLD; 300 repeated aborts -> reset_count saturates at 255.
- Assert reset_in low mid-STRETCH -> outputs 0 and reset_count 0 immediately (no clock edge); NUM_DOMAINS=1 build reaches RUN one cycle after STRETCH ends.
